bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 25 ++
 rtl/bit_counter.sv | 41 ++++
 rtl/bit_serializer.sv | 106 ++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared encodings for the serializer and the downstream sequence detector.
// Also holds the legal WIDTH bounds and the counter width helper.
package bit_serializer_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // Detector states: number of consecutive 1s seen so far on the serial line.
  typedef enum logic [1:0] {
    DET_S0 = 2'd0,
    DET_S1 = 2'd1,
    DET_S2 = 2'd2,
    DET_S3 = 2'd3
  } det_state_e;

  localparam int unsigned SER_WIDTH_MIN = 2;
  localparam int unsigned SER_WIDTH_MAX = 32;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Bit index counter 0..WIDTH-1, wraps to 0 after the last index.
// Clear wins over increment; last_o flags index WIDTH-1 from registered state.
module bit_counter
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW   = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST_IDX);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: one clock from handshake to first bit, WIDTH bits per word.
// load_ready is high in IDLE and on the last bit, so back-to-back words stream without a bubble.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             flush,
  output logic             out,
  output logic             out_valid,
  output logic             frame_done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_adv;
  logic [CW-1:0]    cnt;
  logic             cnt_last;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             last_bit;
  logic             xfer;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (cnt_inc),
    .clr_i  (cnt_clr),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  assign last_bit   = (state_q == SER_SHIFT) && cnt_last;
  assign load_ready = (state_q == SER_IDLE) || last_bit;
  // flush blocks the handshake even though load_ready remains asserted.
  assign xfer       = load_valid && load_ready && !flush;

  assign shreg_adv = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (flush) begin
      state_d = SER_IDLE;
      shreg_d = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        SER_IDLE: begin
          cnt_clr = 1'b1;
          if (xfer) begin
            state_d = SER_SHIFT;
            shreg_d = data_in;
          end
        end
        SER_SHIFT: begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            if (xfer) begin
              shreg_d = data_in;
            end else begin
              state_d = SER_IDLE;
              shreg_d = '0;
            end
          end else begin
            shreg_d = shreg_adv;
          end
        end
        default: begin
          state_d = SER_IDLE;
          shreg_d = '0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SER_IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Serial outputs come only from registers; the shift register is zero in IDLE.
  assign out        = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign out_valid  = (state_q == SER_SHIFT);
  assign frame_done = last_bit;

endmodule
